promotion_ctrl: RTL and testbench

//  Sequences pawn promotion for one colour's pawn sprites. On a pawn reaching the last rank it runs
//  a key-driven piece-selection FSM, holds game moves meanwhile, and keeps a per-pawn table of

---
 rtl/promotion_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_promotion_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/promotion_ctrl.sv
// Pawn promotion sequencer for one colour's pawn sprites.
// A pawn that reaches the last rank opens a key-driven piece selection.
// Game moves are held while the selection is open. A per-pawn table of
// promotion codes feeds the sprite drawer. The table the drawer sees is
// only updated on a vsync falling edge, so a sprite never tears mid-frame.
module promotion_ctrl #(
   parameter int         NUM_PAWNS     = 8,
   parameter logic [2:0] DEFAULT_PIECE = 3'd1,
   localparam int        IDX_W         = $clog2(NUM_PAWNS)
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   input  logic             new_game,
   input  logic             vs,
   input  logic             pawn_arrive,
   input  logic [IDX_W-1:0] arrive_idx,
   input  logic             key_next,
   input  logic             key_prev,
   input  logic             key_confirm,
   input  logic [IDX_W-1:0] draw_idx,
   output logic [2:0]       promotion,
   output logic             hold,
   output logic             done,
   output logic             arrive_drop
);

   typedef enum logic [1:0] {IDLE, SELECT, WAIT_FRAME} state_t;

   state_t           state, state_nxt;
   logic [2:0]       wtab [NUM_PAWNS];
   logic [2:0]       dtab [NUM_PAWNS];
   logic [2:0]       cand;
   logic [IDX_W-1:0] pidx;
   logic             key_next_q, key_prev_q, key_confirm_q, vs_q;
   logic             e_next, e_prev, e_confirm, fb;
   logic             arrive_ok, accept, commit, finish, drop;

   // Candidate ring, forward direction: queen, knight, rook, bishop, queen.
   function automatic logic [2:0] next_piece(input logic [2:0] c);
      case (c)
         3'd1:    next_piece = 3'd2;
         3'd2:    next_piece = 3'd3;
         3'd3:    next_piece = 3'd4;
         default: next_piece = 3'd1;
      endcase
   endfunction

   // Candidate ring, reverse direction.
   function automatic logic [2:0] prev_piece(input logic [2:0] c);
      case (c)
         3'd1:    prev_piece = 3'd4;
         3'd4:    prev_piece = 3'd3;
         3'd3:    prev_piece = 3'd2;
         default: prev_piece = 3'd1;
      endcase
   endfunction

   assign e_next    = key_next    & ~key_next_q;
   assign e_prev    = key_prev    & ~key_prev_q;
   assign e_confirm = key_confirm & ~key_confirm_q;
   assign fb        = vs_q & ~vs;
   assign arrive_ok = (32'(arrive_idx) < NUM_PAWNS) && (wtab[arrive_idx] == 3'd0);
   assign hold      = (state != IDLE);

   // State register.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic and single-cycle control strobes; new_game overrides everything.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      commit    = 1'b0;
      finish    = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (pawn_arrive) begin
               if (arrive_ok) begin
                  accept    = 1'b1;
                  state_nxt = SELECT;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         SELECT: begin
            drop = pawn_arrive;
            if (e_confirm) begin
               commit    = 1'b1;
               state_nxt = WAIT_FRAME;
            end
         end
         WAIT_FRAME: begin
            drop = pawn_arrive;
            if (fb) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (new_game) begin
         state_nxt = IDLE;
         accept    = 1'b0;
         commit    = 1'b0;
         finish    = 1'b0;
         drop      = 1'b0;
      end
   end

   // Key and vsync history; kept across new_game so a held key does not re-fire.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         key_next_q    <= 1'b0;
         key_prev_q    <= 1'b0;
         key_confirm_q <= 1'b0;
         vs_q          <= 1'b1;
      end else begin
         key_next_q    <= key_next;
         key_prev_q    <= key_prev;
         key_confirm_q <= key_confirm;
         vs_q          <= vs;
      end
   end

   // Candidate piece and the pawn being promoted; confirm freezes the candidate.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         cand <= DEFAULT_PIECE;
         pidx <= '0;
      end else if (new_game) begin
         cand <= DEFAULT_PIECE;
      end else if (accept) begin
         cand <= DEFAULT_PIECE;
         pidx <= arrive_idx;
      end else if (state == SELECT && !e_confirm) begin
         if (e_next && !e_prev)      cand <= next_piece(cand);
         else if (e_prev && !e_next) cand <= prev_piece(cand);
      end
   end

   // Working table takes the confirmed choice; displayed table follows it at frame boundaries,
   // with the open selection previewed on top.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PAWNS; i++) begin
            wtab[i] <= 3'd0;
            dtab[i] <= 3'd0;
         end
      end else if (new_game) begin
         for (int i = 0; i < NUM_PAWNS; i++) begin
            wtab[i] <= 3'd0;
            dtab[i] <= 3'd0;
         end
      end else begin
         if (commit) wtab[pidx] <= cand;
         if (fb) begin
            for (int i = 0; i < NUM_PAWNS; i++) dtab[i] <= wtab[i];
            if (state == SELECT) dtab[pidx] <= cand;
         end
      end
   end

   // Registered status pulses.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         done        <= 1'b0;
         arrive_drop <= 1'b0;
      end else begin
         done        <= finish;
         arrive_drop <= drop;
      end
   end

   // Drawer lookup; indices beyond the tracked pawns read as a plain pawn.
   always_comb begin
      promotion = 3'd0;
      if (32'(draw_idx) < NUM_PAWNS) promotion = dtab[draw_idx];
   end

endmodule

// File: tb/tb_promotion_ctrl.sv
// Self-checking bench for promotion_ctrl: vector tables applied through a scoreboard queue,
// plus hand-written sequences for the held key and the asynchronous reset.
module tb_promotion_ctrl;

   logic       vga_clk = 1'b0;
   logic       reset_n, new_game, vs, pawn_arrive, key_next, key_prev, key_confirm;
   logic [2:0] arrive_idx, draw_idx, promotion;
   logic       hold, done, arrive_drop;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      bit         ng, vsi, arr;
      logic [2:0] aidx;
      bit         kn, kp, kc;
      logic [2:0] didx;
      logic [2:0] ep;
      bit         eh, ed, edr;
   } rec_t;

   rec_t vec_a[$];
   rec_t vec_b[$];
   rec_t vec_c[$];
   rec_t sb[$];
   int   step_no = 0;

   promotion_ctrl #(.NUM_PAWNS(8), .DEFAULT_PIECE(3'd1)) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .new_game(new_game), .vs(vs),
      .pawn_arrive(pawn_arrive), .arrive_idx(arrive_idx),
      .key_next(key_next), .key_prev(key_prev), .key_confirm(key_confirm),
      .draw_idx(draw_idx), .promotion(promotion), .hold(hold), .done(done),
      .arrive_drop(arrive_drop)
   );

   always #5 vga_clk = ~vga_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic rec_t mk(input string nm, input bit ng, input bit vsi, input bit arr,
                               input logic [2:0] aidx, input bit kn, input bit kp, input bit kc,
                               input logic [2:0] didx, input logic [2:0] ep, input bit eh,
                               input bit ed, input bit edr);
      rec_t r;
      r.name = nm; r.ng = ng; r.vsi = vsi; r.arr = arr; r.aidx = aidx;
      r.kn = kn; r.kp = kp; r.kc = kc; r.didx = didx;
      r.ep = ep; r.eh = eh; r.ed = ed; r.edr = edr;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, queue its expectation, check it #1 after the edge.
   task automatic drive(input rec_t r);
      rec_t e;
      new_game = r.ng; vs = r.vsi; pawn_arrive = r.arr; arrive_idx = r.aidx;
      key_next = r.kn; key_prev = r.kp; key_confirm = r.kc; draw_idx = r.didx;
      sb.push_back(r);
      @(posedge vga_clk);
      #1;
      e = sb.pop_front();
      step_no++;
      chk($sformatf("%0d:%s promotion", step_no, e.name), {5'd0, promotion}, {5'd0, e.ep});
      chk($sformatf("%0d:%s hold", step_no, e.name), {7'd0, hold}, {7'd0, e.eh});
      chk($sformatf("%0d:%s done", step_no, e.name), {7'd0, done}, {7'd0, e.ed});
      chk($sformatf("%0d:%s arrive_drop", step_no, e.name), {7'd0, arrive_drop}, {7'd0, e.edr});
   endtask

   initial begin
      //            name         ng vs ar ai kn kp kc di  ep h d dr
      vec_a.push_back(mk("idle",       0,1,0,0, 0,0,0, 3, 0,0,0,0));
      vec_a.push_back(mk("arrive3",    0,1,1,3, 0,0,0, 3, 0,1,0,0));
      vec_a.push_back(mk("fb_prev1",   0,0,0,0, 0,0,0, 3, 1,1,0,0));
      vec_a.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 3, 1,1,0,0));
      vec_a.push_back(mk("next_a",     0,1,0,0, 1,0,0, 3, 1,1,0,0));
      vec_a.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 1,1,0,0));
      vec_a.push_back(mk("next_b",     0,1,0,0, 1,0,0, 3, 1,1,0,0));
      vec_a.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 1,1,0,0));
      vec_a.push_back(mk("fb_cand3",   0,0,0,0, 0,0,0, 3, 3,1,0,0));
      vec_a.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 3, 3,1,0,0));
      vec_a.push_back(mk("prev_a",     0,1,0,0, 0,1,0, 3, 3,1,0,0));
      vec_a.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 3,1,0,0));
      vec_a.push_back(mk("prev_b",     0,1,0,0, 0,1,0, 3, 3,1,0,0));
      vec_a.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 3,1,0,0));
      vec_a.push_back(mk("prev_c",     0,1,0,0, 0,1,0, 3, 3,1,0,0));
      vec_a.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 3,1,0,0));
      vec_a.push_back(mk("fb_cand4",   0,0,0,0, 0,0,0, 3, 4,1,0,0));
      vec_a.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 3, 4,1,0,0));

      vec_b.push_back(mk("fb_held1",   0,0,0,0, 0,0,0, 3, 1,1,0,0));
      vec_b.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 3, 1,1,0,0));
      vec_b.push_back(mk("next_c",     0,1,0,0, 1,0,0, 3, 1,1,0,0));
      vec_b.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 1,1,0,0));
      vec_b.push_back(mk("arrive5_sel",0,1,1,5, 0,0,0, 3, 1,1,0,1));
      vec_b.push_back(mk("drop_clear", 0,1,0,0, 0,0,0, 3, 1,1,0,0));
      vec_b.push_back(mk("draw5",      0,1,0,0, 0,0,0, 5, 0,1,0,0));
      vec_b.push_back(mk("next_prev",  0,1,0,0, 1,1,0, 3, 1,1,0,0));
      vec_b.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 1,1,0,0));
      vec_b.push_back(mk("fb_cand2",   0,0,0,0, 0,0,0, 3, 2,1,0,0));
      vec_b.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 3, 2,1,0,0));
      vec_b.push_back(mk("conf_next",  0,1,0,0, 1,0,1, 3, 2,1,0,0));
      vec_b.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 2,1,0,0));
      vec_b.push_back(mk("wait_key",   0,1,0,0, 1,0,0, 3, 2,1,0,0));
      vec_b.push_back(mk("rel",        0,1,0,0, 0,0,0, 3, 2,1,0,0));
      vec_b.push_back(mk("fb_done",    0,0,0,0, 0,0,0, 3, 2,0,1,0));
      vec_b.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 3, 2,0,0,0));
      vec_b.push_back(mk("arrive3_dup",0,1,1,3, 0,0,0, 3, 2,0,0,1));
      vec_b.push_back(mk("drop_clear", 0,1,0,0, 0,0,0, 3, 2,0,0,0));
      vec_b.push_back(mk("arrive5",    0,1,1,5, 0,0,0, 5, 0,1,0,0));
      vec_b.push_back(mk("fb_prev5",   0,0,0,0, 0,0,0, 5, 1,1,0,0));
      vec_b.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 5, 1,1,0,0));
      vec_b.push_back(mk("next5",      0,1,0,0, 1,0,0, 5, 1,1,0,0));
      vec_b.push_back(mk("rel",        0,1,0,0, 0,0,0, 5, 1,1,0,0));
      vec_b.push_back(mk("conf_at_fb", 0,0,0,0, 0,0,1, 5, 2,1,0,0));
      vec_b.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 5, 2,1,0,0));
      vec_b.push_back(mk("fb_done5",   0,0,0,0, 0,0,0, 5, 2,0,1,0));
      vec_b.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 5, 2,0,0,0));
      vec_b.push_back(mk("draw3_kept", 0,1,0,0, 0,0,0, 3, 2,0,0,0));
      vec_b.push_back(mk("arrive6",    0,1,1,6, 0,0,0, 6, 0,1,0,0));
      vec_b.push_back(mk("fb_prev6",   0,0,0,0, 0,0,0, 6, 1,1,0,0));
      vec_b.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 6, 1,1,0,0));
      vec_b.push_back(mk("confirm6",   0,1,0,0, 0,0,1, 6, 1,1,0,0));
      vec_b.push_back(mk("rel",        0,1,0,0, 0,0,0, 6, 1,1,0,0));

      vec_c.push_back(mk("post_rst",   0,1,0,0, 0,0,0, 3, 0,0,0,0));
      vec_c.push_back(mk("arrive2",    0,1,1,2, 0,0,0, 2, 0,1,0,0));
      vec_c.push_back(mk("fb_prev2",   0,0,0,0, 0,0,0, 2, 1,1,0,0));
      vec_c.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 2, 1,1,0,0));
      vec_c.push_back(mk("confirm2",   0,1,0,0, 0,0,1, 2, 1,1,0,0));
      vec_c.push_back(mk("rel",        0,1,0,0, 0,0,0, 2, 1,1,0,0));
      vec_c.push_back(mk("fb_done2",   0,0,0,0, 0,0,0, 2, 1,0,1,0));
      vec_c.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 2, 1,0,0,0));
      vec_c.push_back(mk("new_game",   1,1,0,0, 0,0,0, 2, 0,0,0,0));
      vec_c.push_back(mk("ng_arrive",  1,1,1,2, 0,0,0, 2, 0,0,0,0));
      vec_c.push_back(mk("fb_cleared", 0,0,0,0, 0,0,0, 2, 0,0,0,0));
      vec_c.push_back(mk("vs_hi",      0,1,0,0, 0,0,0, 2, 0,0,0,0));
      vec_c.push_back(mk("rearrive2",  0,1,1,2, 0,0,0, 2, 0,1,0,0));

      new_game = 0; vs = 1; pawn_arrive = 0; arrive_idx = 0;
      key_next = 0; key_prev = 0; key_confirm = 0; draw_idx = 3;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge vga_clk);
      #1;
      chk("reset promotion", {5'd0, promotion}, 8'd0);
      chk("reset hold", {7'd0, hold}, 8'd0);
      chk("reset done", {7'd0, done}, 8'd0);
      chk("reset arrive_drop", {7'd0, arrive_drop}, 8'd0);
      reset_n = 1'b1;

      foreach (vec_a[i]) drive(vec_a[i]);

      // Key held for 100 clocks must step the candidate once (4 -> 1).
      for (int i = 0; i < 100; i++) drive(mk("held_next", 0,1,0,0, 1,0,0, 3, 4,1,0,0));
      drive(mk("held_rel", 0,1,0,0, 0,0,0, 3, 4,1,0,0));

      foreach (vec_b[i]) drive(vec_b[i]);

      // Asynchronous reset in WAIT_FRAME: outputs clear without a clock edge.
      reset_n = 1'b0;
      #1;
      chk("async_rst hold", {7'd0, hold}, 8'd0);
      chk("async_rst done", {7'd0, done}, 8'd0);
      chk("async_rst promotion3", {5'd0, promotion}, 8'd0);
      draw_idx = 3'd6;
      #1;
      chk("async_rst promotion6", {5'd0, promotion}, 8'd0);
      draw_idx = 3'd5;
      #1;
      chk("async_rst promotion5", {5'd0, promotion}, 8'd0);
      @(negedge vga_clk);
      reset_n = 1'b1;

      foreach (vec_c[i]) drive(vec_c[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
